// File: rtl/wb_sram_slave.sv
// ---------------------------------------------------------------------------
// wb_sram_slave
//   Wishbone slave controller for a single-port synchronous SRAM. It sits
//   directly below the interconnect slave port and turns single and burst
//   Wishbone cycles into one SRAM access per beat. Each access can be
//   followed by WAIT_CYCLES stall cycles before the beat is acknowledged.
//
//   Ports
//     clk, reset        core clock, asynchronous active-high reset
//     s_wbd_*_i         Wishbone request: data, byte address (base 0),
//                       byte selects, burst length (0 means 1), burst-ready,
//                       write enable, cycle, strobe
//     s_wbd_dat_o       registered read data
//     s_wbd_ack_o       beat acknowledge        (gated by s_wbd_cyc_i)
//     s_wbd_lack_o      last-beat acknowledge   (gated by s_wbd_cyc_i)
//     s_wbd_err_o       error response          (gated by s_wbd_cyc_i)
//     mem_*_o           SRAM chip enable, write enable, byte write mask,
//                       word address and write data
//     mem_rdata_i       SRAM read data, valid the cycle after a read access
//
//   Build option
//     WB_SRAM_ADDR_CHECK_EN  when defined, a request whose byte address has
//                            any bit set above the SRAM window gets a
//                            one-cycle err instead of an SRAM access. When
//                            undefined, upper address bits alias and err is
//                            tied low.
// ---------------------------------------------------------------------------
module wb_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_AW      = 14,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   s_wbd_dat_i,
  input  logic [31:0]             s_wbd_adr_i,
  input  logic [DATA_WIDTH/8-1:0] s_wbd_sel_i,
  input  logic [9:0]              s_wbd_bl_i,
  input  logic                    s_wbd_bry_i,
  input  logic                    s_wbd_we_i,
  input  logic                    s_wbd_cyc_i,
  input  logic                    s_wbd_stb_i,
  output logic [DATA_WIDTH-1:0]   s_wbd_dat_o,
  output logic                    s_wbd_ack_o,
  output logic                    s_wbd_lack_o,
  output logic                    s_wbd_err_o,
  output logic                    mem_ce_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  output logic [MEM_AW-1:0]       mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int SW = DATA_WIDTH / 8;
  // Loaded on entry to WAIT; WAIT then lasts WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    ACK,
    NEXT,
    ERR
  } state_t;

  state_t            state;
  logic [MEM_AW-1:0] addr_q;
  logic              we_q;
  logic [SW-1:0]     sel_q;
  logic [9:0]        beats_q;
  logic [3:0]        wait_q;
  logic              rd_cap_q;
  logic              ack_q;
  logic              lack_q;
  logic              err_q;

  logic              req;
  logic [MEM_AW-1:0] req_addr;
  logic              addr_bad;
  logic              unused_sig;

  assign req      = s_wbd_cyc_i & s_wbd_stb_i;
  assign req_addr = s_wbd_adr_i[MEM_AW+1:2];

`ifdef WB_SRAM_ADDR_CHECK_EN
  assign addr_bad    = |s_wbd_adr_i[31:MEM_AW+2];
  assign s_wbd_err_o = err_q & s_wbd_cyc_i;
  assign unused_sig  = ^s_wbd_adr_i[1:0];
`else
  assign addr_bad    = 1'b0;
  assign s_wbd_err_o = 1'b0;
  assign unused_sig  = ^{s_wbd_adr_i[31:MEM_AW+2], s_wbd_adr_i[1:0], err_q};
`endif

  // Responses are never visible outside an active bus cycle.
  assign s_wbd_ack_o  = ack_q  & s_wbd_cyc_i;
  assign s_wbd_lack_o = lack_q & s_wbd_cyc_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      beats_q     <= '0;
      wait_q      <= '0;
      rd_cap_q    <= 1'b0;
      ack_q       <= 1'b0;
      lack_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_wmask_o <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      s_wbd_dat_o <= '0;
    end else begin
      // Strobe-type outputs are high only for the single cycle of the
      // state that owns them; address and write data simply hold.
      ack_q       <= 1'b0;
      lack_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_wmask_o <= '0;
      rd_cap_q    <= 1'b0;

      // SRAM read data arrives one cycle after the access cycle; it is
      // captured on the edge that ends that cycle. With WAIT_CYCLES=0 this
      // is the same edge that ends the ack cycle.
      if (rd_cap_q) begin
        s_wbd_dat_o <= mem_rdata_i;
      end

      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= s_wbd_we_i;
            sel_q   <= s_wbd_sel_i;
            addr_q  <= req_addr;
            beats_q <= (s_wbd_bl_i == 10'd0) ? 10'd1 : s_wbd_bl_i;
            if (addr_bad) begin
              state <= ERR;
              err_q <= 1'b1;
            end else begin
              state       <= ACCESS;
              mem_ce_o    <= 1'b1;
              mem_we_o    <= s_wbd_we_i;
              mem_wmask_o <= s_wbd_we_i ? s_wbd_sel_i : '0;
              mem_addr_o  <= req_addr;
              mem_wdata_o <= s_wbd_dat_i;
            end
          end
        end

        ACCESS: begin
          if (!s_wbd_cyc_i) begin
            state <= IDLE;
          end else begin
            rd_cap_q <= ~we_q;
            if (WAIT_CYCLES > 0) begin
              state  <= WAIT;
              wait_q <= WAIT_INIT;
            end else begin
              state  <= ACK;
              ack_q  <= 1'b1;
              lack_q <= (beats_q == 10'd1);
            end
          end
        end

        WAIT: begin
          if (!s_wbd_cyc_i) begin
            state <= IDLE;
          end else if (wait_q == 4'd0) begin
            state  <= ACK;
            ack_q  <= 1'b1;
            lack_q <= (beats_q == 10'd1);
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end

        ACK: begin
          if (!s_wbd_cyc_i) begin
            state <= IDLE;
          end else begin
            beats_q <= beats_q - 10'd1;
            state   <= (beats_q > 10'd1) ? NEXT : IDLE;
          end
        end

        NEXT: begin
          if (!s_wbd_cyc_i) begin
            state <= IDLE;
          end else if (s_wbd_bry_i) begin
            // Word address wraps at the top of the SRAM window.
            state       <= ACCESS;
            addr_q      <= addr_q + MEM_AW'(1);
            mem_ce_o    <= 1'b1;
            mem_we_o    <= we_q;
            mem_wmask_o <= we_q ? sel_q : '0;
            mem_addr_o  <= addr_q + MEM_AW'(1);
            mem_wdata_o <= s_wbd_dat_i;
          end
        end

        ERR: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
module tb_wb_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dat_i;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [9:0]  bl;
  logic        bry;
  logic        we;
  logic        cyc;
  logic        stb;

  logic [31:0] dat0, wdata0, rdata0;
  logic        ack0, lack0, err0, ce0, mwe0;
  logic [3:0]  wmask0;
  logic [13:0] maddr0;

  logic [31:0] dat2, wdata2, rdata2;
  logic        ack2, lack2, err2, ce2, mwe2;
  logic [3:0]  wmask2;
  logic [13:0] maddr2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_sram_slave #(.DATA_WIDTH(32), .MEM_AW(14), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .s_wbd_dat_i(dat_i), .s_wbd_adr_i(adr), .s_wbd_sel_i(sel), .s_wbd_bl_i(bl),
    .s_wbd_bry_i(bry), .s_wbd_we_i(we), .s_wbd_cyc_i(cyc), .s_wbd_stb_i(stb),
    .s_wbd_dat_o(dat0), .s_wbd_ack_o(ack0), .s_wbd_lack_o(lack0), .s_wbd_err_o(err0),
    .mem_ce_o(ce0), .mem_we_o(mwe0), .mem_wmask_o(wmask0), .mem_addr_o(maddr0),
    .mem_wdata_o(wdata0), .mem_rdata_i(rdata0)
  );

  wb_sram_slave #(.DATA_WIDTH(32), .MEM_AW(14), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset),
    .s_wbd_dat_i(dat_i), .s_wbd_adr_i(adr), .s_wbd_sel_i(sel), .s_wbd_bl_i(bl),
    .s_wbd_bry_i(bry), .s_wbd_we_i(we), .s_wbd_cyc_i(cyc), .s_wbd_stb_i(stb),
    .s_wbd_dat_o(dat2), .s_wbd_ack_o(ack2), .s_wbd_lack_o(lack2), .s_wbd_err_o(err2),
    .mem_ce_o(ce2), .mem_we_o(mwe2), .mem_wmask_o(wmask2), .mem_addr_o(maddr2),
    .mem_wdata_o(wdata2), .mem_rdata_i(rdata2)
  );

  // Synchronous SRAM models, one per DUT, with byte write masks.
  logic [31:0] mem0 [0:16383];
  logic [31:0] mem2 [0:16383];

  always @(posedge clk) begin
    if (ce0) begin
      if (mwe0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) mem0[maddr0][8*b +: 8] <= wdata0[8*b +: 8];
      end else begin
        rdata0 <= mem0[maddr0];
      end
    end
  end

  always @(posedge clk) begin
    if (ce2) begin
      if (mwe2) begin
        for (int b = 0; b < 4; b++)
          if (wmask2[b]) mem2[maddr2][8*b +: 8] <= wdata2[8*b +: 8];
      end else begin
        rdata2 <= mem2[maddr2];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Single-beat transfer on the zero-wait DUT (bl=0 must behave as 1 beat).
  task automatic single(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input string tag);
    logic [13:0] wa;
    wa = a[15:2];
    we = w; adr = a; dat_i = d; sel = s; bl = 10'd0; bry = 1'b1;
    cyc = 1'b1; stb = 1'b1;
    tick();
    chk1({tag, "_ce"}, ce0, 1'b1);
    chk1({tag, "_we"}, mwe0, w);
    chk({tag, "_addr"}, 32'(maddr0), 32'(wa));
    chk({tag, "_wmask"}, 32'(wmask0), w ? 32'(s) : 32'd0);
    if (w) chk({tag, "_wdata"}, wdata0, d);
    chk1({tag, "_ack_early"}, ack0, 1'b0);
    tick();
    chk1({tag, "_ack"}, ack0, 1'b1);
    chk1({tag, "_lack"}, lack0, 1'b1);
    chk1({tag, "_err"}, err0, 1'b0);
    chk1({tag, "_ce_off"}, ce0, 1'b0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk1({tag, "_ack_done"}, ack0, 1'b0);
  endtask

  logic [13:0] burst_addr [4];
  logic [31:0] burst_dat  [4];

  initial begin
    burst_addr = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    burst_dat  = '{32'h0B0B_0001, 32'h0B0B_0002, 32'h0B0B_0003, 32'h0B0B_0004};

    reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0;
    sel = '0; bl = '0; bry = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_ack", ack0, 1'b0);
    chk1("rst_lack", lack0, 1'b0);
    chk1("rst_err", err0, 1'b0);
    chk1("rst_ce", ce0, 1'b0);
    chk1("rst_we", mwe0, 1'b0);
    chk("rst_wmask", 32'(wmask0), 32'd0);
    chk("rst_addr", 32'(maddr0), 32'd0);
    chk("rst_wdata", wdata0, 32'd0);
    chk("rst_dat", dat0, 32'd0);
    chk1("rst_ce2", ce2, 1'b0);
    reset = 1'b0;

    // Partial handshakes in IDLE do nothing.
    stb = 1'b1; cyc = 1'b0;
    tick(); tick();
    chk1("idle_stb_only_ce", ce0, 1'b0);
    cyc = 1'b1; stb = 1'b0;
    tick(); tick();
    chk1("idle_cyc_only_ce", ce0, 1'b0);
    chk1("idle_cyc_only_ack", ack0, 1'b0);
    cyc = 1'b0; stb = 1'b0;
    tick();

    // Single write then read.
    single(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, "wr100");
    single(1'b0, 32'h100, 32'h0, 4'hF, "rd100");
    chk("rd100_dat", dat0, 32'hDEAD_BEEF);
    single(1'b1, 32'h104, 32'hCAFE_F00D, 4'hF, "wr104");

    // Byte mask.
    single(1'b1, 32'h0, 32'h1122_3344, 4'hF, "wr0");
    single(1'b1, 32'h0, 32'hAABB_CCDD, 4'h2, "wrmask");
    single(1'b0, 32'h0, 32'h0, 4'hF, "rdmask");
    chk("rdmask_dat", dat0, 32'h1122_CC44);

    // Burst read across the top of the SRAM window.
    single(1'b1, 32'hFFF8, burst_dat[0], 4'hF, "pre0");
    single(1'b1, 32'hFFFC, burst_dat[1], 4'hF, "pre1");
    single(1'b1, 32'h0000, burst_dat[2], 4'hF, "pre2");
    single(1'b1, 32'h0004, burst_dat[3], 4'hF, "pre3");
    we = 1'b0; adr = 32'hFFF8; bl = 10'd4; bry = 1'b1; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;
    for (int b = 0; b < 4; b++) begin
      tick();
      chk1($sformatf("burst%0d_ce", b), ce0, 1'b1);
      chk($sformatf("burst%0d_addr", b), 32'(maddr0), 32'(burst_addr[b]));
      tick();
      chk1($sformatf("burst%0d_ack", b), ack0, 1'b1);
      chk1($sformatf("burst%0d_lack", b), lack0, b == 3);
      if (b < 3) begin
        tick();
        chk1($sformatf("burst%0d_gap_ack", b), ack0, 1'b0);
        chk1($sformatf("burst%0d_gap_ce", b), ce0, 1'b0);
        chk($sformatf("burst%0d_dat", b), dat0, burst_dat[b]);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk("burst3_dat", dat0, burst_dat[3]);
    chk1("burst_end_ack", ack0, 1'b0);

`ifdef WB_SRAM_ADDR_CHECK_EN
    // Out-of-window address gets a one-cycle error, no access.
    we = 1'b0; adr = 32'h0001_0000; bl = 10'd1; cyc = 1'b1; stb = 1'b1;
    tick();
    chk1("err_err", err0, 1'b1);
    chk1("err_ce", ce0, 1'b0);
    chk1("err_ack", ack0, 1'b0);
    chk1("err_err2", err2, 1'b1);
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk1("err_clear", err0, 1'b0);
    chk1("err_ce_after", ce0, 1'b0);
`else
    // Upper address bits alias onto the SRAM window.
    single(1'b0, 32'h0001_0100, 32'h0, 4'hF, "alias");
    chk("alias_dat", dat0, 32'hDEAD_BEEF);
    chk1("alias_err", err0, 1'b0);
`endif

    // Wait states and burst-ready stall on the two-wait DUT.
    we = 1'b0; adr = 32'h100; bl = 10'd2; bry = 1'b1; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;
    tick();
    chk1("ws_ce1", ce2, 1'b1);
    chk("ws_addr1", 32'(maddr2), 32'h40);
    tick();
    chk1("ws_n2_ce", ce2, 1'b0);
    chk1("ws_n2_ack", ack2, 1'b0);
    tick();
    chk1("ws_n3_ack", ack2, 1'b0);
    tick();
    chk1("ws_ack1", ack2, 1'b1);
    chk1("ws_lack1", lack2, 1'b0);
    chk("ws_dat1", dat2, 32'hDEAD_BEEF);
    bry = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1($sformatf("ws_stall%0d_ce", i), ce2, 1'b0);
      chk1($sformatf("ws_stall%0d_ack", i), ack2, 1'b0);
    end
    bry = 1'b1;
    tick();
    chk1("ws_ce2", ce2, 1'b1);
    chk("ws_addr2", 32'(maddr2), 32'h41);
    tick();
    chk1("ws_b2_n1_ack", ack2, 1'b0);
    tick();
    chk1("ws_b2_n2_ack", ack2, 1'b0);
    tick();
    chk1("ws_ack2", ack2, 1'b1);
    chk1("ws_lack2", lack2, 1'b1);
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk("ws_dat2", dat2, 32'hCAFE_F00D);

    // Abort during WAIT, then a new request on the very next cycle.
    we = 1'b0; adr = 32'h0; bl = 10'd4; cyc = 1'b1; stb = 1'b1;
    tick();
    chk1("abort_ce", ce2, 1'b1);
    tick();
    chk1("abort_wait_ack", ack2, 1'b0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk1("abort_no_ce", ce2, 1'b0);
    chk1("abort_no_ack", ack2, 1'b0);
    adr = 32'h104; bl = 10'd1; cyc = 1'b1; stb = 1'b1;
    tick();
    chk1("after_abort_ce", ce2, 1'b1);
    chk("after_abort_addr", 32'(maddr2), 32'h41);
    tick();
    chk1("after_abort_ce_off", ce2, 1'b0);
    tick();
    tick();
    chk1("after_abort_ack", ack2, 1'b1);
    chk1("after_abort_lack", lack2, 1'b1);
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk("after_abort_dat", dat2, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of a burst.
    we = 1'b0; adr = 32'h104; bl = 10'd4; dat_i = 32'h5555_AAAA;
    cyc = 1'b1; stb = 1'b1;
    tick();
    chk1("mid_ce", ce0, 1'b1);
    chk("mid_wdata", wdata0, 32'h5555_AAAA);
    tick();
    chk1("mid_ack", ack0, 1'b1);
    chk1("mid_lack", lack0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk1("arst_ack", ack0, 1'b0);
    chk1("arst_lack", lack0, 1'b0);
    chk1("arst_ce", ce0, 1'b0);
    chk1("arst_we", mwe0, 1'b0);
    chk("arst_wmask", 32'(wmask0), 32'd0);
    chk("arst_addr", 32'(maddr0), 32'd0);
    chk("arst_wdata", wdata0, 32'd0);
    chk("arst_dat", dat0, 32'd0);
    chk("arst_dat2", dat2, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick();
    chk1("post_rst_ce", ce0, 1'b0);
    chk1("post_rst_ack", ack0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
